// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Computes the low 16 bits of a 16x16 product with shift-and-add on the
//   shared 16-bit ALU. Each of the 16 iterations takes three cycles
//   (ADD, SHL, SHR), so a result appears 48 cycles after the operands are
//   accepted.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready only in IDLE)
//   in_a, in_b            multiplicand, multiplier
//   out_valid/out_ready   result handshake (out_valid only in DONE)
//   out_p                 product register, held while out_valid is high
//   busy                  high during ADD, SHL and SHR
//   alu_a, alu_b          ALU operands driven by this block
//   alu_fs, alu_cin       ALU function select and carry-in
//   alu_f                 combinational ALU result fed back
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_fs,
  output logic        alu_cin,
  input  logic [15:0] alu_f
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  localparam logic [4:0] FS_ZERO = 5'b00000;
  localparam logic [4:0] FS_PASS = 5'b01100;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_SHL  = 5'b11000;
  localparam logic [4:0] FS_SHR  = 5'b11010;

  state_e      state_q, state_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_fs   = FS_ZERO;
    alu_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_ADD;
          prod_d   = '0;
          mcand_d  = in_a;
          mplier_d = in_b;
          iter_d   = '0;
        end
      end
      S_ADD: begin
        // A clear multiplier bit still goes through the ALU as pass-A so
        // every iteration has the same length.
        alu_a = prod_q;
        if (mplier_q[0]) begin
          alu_fs = FS_ADD;
          alu_b  = mcand_q;
        end else begin
          alu_fs = FS_PASS;
        end
        prod_d  = alu_f;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_a   = mcand_q;
        alu_fs  = FS_SHL;
        mcand_d = alu_f;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_a    = mplier_q;
        alu_fs   = FS_SHR;
        mplier_d = alu_f;
        if (iter_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + 4'd1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ADD) || (state_q == S_SHL) || (state_q == S_SHR);
  assign out_p     = prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
//   Directed bench for alu_mul_sequencer. Provides a behavioural ALU on the
//   alu_* ports, pushes expected products to a queue on each accept and
//   pops them when the block presents a result.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_fs;
  logic        alu_cin;
  logic [15:0] alu_f;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  alu_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fs    (alu_fs),
    .alu_cin   (alu_cin),
    .alu_f     (alu_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU for the encodings the sequencer uses.
  always_comb begin
    case (alu_fs)
      5'b10100: alu_f = alu_a + alu_b + {15'd0, alu_cin};
      5'b01100: alu_f = alu_a;
      5'b11000: alu_f = alu_a << 1;
      5'b11010: alu_f = alu_a >> 1;
      default:  alu_f = 16'h0000;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full operation. hold: cycles with out_ready low once out_valid rises.
  // drvchk: verify ALU drive pattern (expects in_b == 1). junk: offer new
  // operands every busy cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit drvchk, input bit junk);
    int cyc;
    int it;
    logic [15:0] expv;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("accept_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    out_ready = (hold == 0);
    step();
    exp_q.push_back(a * b);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (drvchk) begin
        it = cyc / 3;
        case (cyc % 3)
          0: begin
            if (it == 0) begin
              chk("drv_add_fs", {11'd0, alu_fs}, 16'b10100);
              chk("drv_add_b", alu_b, a);
            end else begin
              chk("drv_pass_fs", {11'd0, alu_fs}, 16'b01100);
              chk("drv_pass_b", alu_b, 16'h0000);
            end
          end
          1: chk("drv_shl_fs", {11'd0, alu_fs}, 16'b11000);
          default: chk("drv_shr_fs", {11'd0, alu_fs}, 16'b11010);
        endcase
        chk("drv_busy", {15'd0, busy}, 16'd1);
      end
      if (junk) begin
        chk("busy_in_ready", {15'd0, in_ready}, 16'd0);
        in_valid = 1'b1;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 16'(cyc), 16'd48);
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else expv = 16'hxxxx;
    chk("product", out_p, expv);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_p", out_p, expv);
      chk("hold_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_ready", {15'd0, in_ready}, 16'd1);
    chk("post_hs_valid", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_out_p", out_p, 16'h0000);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_fs", {11'd0, alu_fs}, 16'h0000);
    chk("rst_alu_cin", {15'd0, alu_cin}, 16'd0);

    // Basic multiply
    run_op(16'd3, 16'd5, 0, 1'b0, 1'b0);

    // Overflow wrap
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0);
    run_op(16'h0100, 16'h0100, 0, 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0101, 0, 1'b0, 1'b0);

    // Zero multiplier with backpressure
    run_op(16'h1234, 16'h0000, 10, 1'b0, 1'b0);

    // ALU drive pattern, then idle drive
    run_op(16'hA5C3, 16'h0001, 0, 1'b1, 1'b0);
    chk("idle_fs", {11'd0, alu_fs}, 16'h0000);
    chk("idle_a", alu_a, 16'h0000);
    chk("idle_b", alu_b, 16'h0000);

    // Operands offered while busy must be ignored
    run_op(16'h1357, 16'h2468, 0, 1'b0, 1'b1);
    chk("junk_no_accept", {15'd0, busy}, 16'd0);

    // Reset at iteration 7
    in_valid = 1'b1;
    in_a = 16'h1234;
    in_b = 16'h5678;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 21; i++) step();
    chk("mid_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("mrst_busy", {15'd0, busy}, 16'd0);
    chk("mrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mrst_out_p", out_p, 16'h0000);
    run_op(16'd7, 16'd9, 0, 1'b0, 1'b0);

    // A few random operations with random backpressure
    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle controller that computes a 16×16 multiply (low 16 bits of the product) on the shared 16-bit ALU using shift-and-add. It owns the ALU's A, B, FS and Cin inputs while busy and receives the ALU's combinational F output back. Operands are taken in and the result is handed out through valid/ready handshakes. The block sits between the datapath control and the ALU, so no dedicated multiplier hardware is required.

## Interface
- No parameters; width is fixed at 16.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Operand pair offered.
- in_ready  out  1  Block can accept operands; high only in IDLE.
- in_a  in  16  Multiplicand.
- in_b  in  16  Multiplier.
- out_valid  out  1  Product available; high only in DONE.
- out_ready  in  1  Consumer accepts product.
- out_p  out  16  Product, in_a*in_b mod 2^16; held stable while out_valid is high.
- busy  out  1  High in ADD, SHL or SHR.
- alu_a  out  16  ALU A operand.
- alu_b  out  16  ALU B operand.
- alu_fs  out  5  ALU function select FS[4:0].
- alu_cin  out  1  ALU carry-in.
- alu_f  in  16  ALU result F; combinational from alu_a, alu_b, alu_fs and alu_cin.

## Operation
- ALU encodings used, as {FS, Cin}:
  - add: 10100,0
  - pass A: 01100,0
  - shift left 1: 11000,0
  - shift right 1: 11010,0
  - zero (idle drive): 00000,0
- Internal registers:
  - prod[15:0], mcand[15:0], mplier[15:0].
  - iter[3:0]: iteration counter.
- States and transitions:
  - IDLE → ADD on in_valid & in_ready. On that edge: prod←0, mcand←in_a, mplier←in_b, iter←0.
  - ADD → SHL. If mplier[0]=1: drive add with alu_a=prod, alu_b=mcand. Otherwise drive pass A with alu_a=prod. prod←alu_f in both cases, so every iteration has the same length.
  - SHL → SHR. Drive shift left with alu_a=mcand; mcand←alu_f.
  - SHR → ADD if iter≠15, then iter←iter+1. SHR → DONE if iter=15. Drive shift right with alu_a=mplier; mplier←alu_f.
  - DONE → IDLE on out_valid & out_ready. Otherwise stay in DONE and hold prod.
- ALU drive outside the active states:
  - In IDLE and DONE, drive the zero encoding with alu_a=alu_b=0.
  - In every state other than ADD-with-add, alu_b=0.
- out_p equals prod at all times. It is meaningful only while out_valid is high.
- The counter never wraps during an operation; exit from SHR occurs at iter=15.
- in_valid while not in IDLE is ignored and does not corrupt state. in_a and in_b are sampled only on the accepting edge.
- A zero multiplier still runs all 16 iterations; there is no early termination.

## Timing
- Reset values: state=IDLE; prod, mcand, mplier and iter all 0. Outputs after reset: in_ready=1, out_valid=0, busy=0, out_p=0, alu_a=0, alu_b=0, alu_fs=00000, alu_cin=0.
- rst asserted in any state (including mid-multiply or in DONE with out_valid high) wins over all other events. On the next edge the block is in IDLE with reset values and the pending result is discarded.
- Latency: if operands are accepted at edge E, out_valid goes high after edge E+48 (16 iterations × 3 cycles).
- Throughput: at most one operation per 50 cycles. in_ready is low during DONE, so a new accept cannot coincide with the output handshake.
- The output handshake completes on an edge where out_valid & out_ready are both high. in_ready rises in the following cycle.
- out_ready held low keeps the block in DONE indefinitely with out_p stable.
- ALU outputs are a combinational decode of state, mplier[0] and the registers. The ALU result is captured on the same cycle's edge, so the path is single-cycle through the ALU.

## Test plan
- Basic multiply: in_a=3, in_b=5, out_ready=1. Required: out_valid rises exactly 48 cycles after the accept edge, out_p=0x000F, in_ready returns 1 on the cycle after the handshake.
- Overflow wrap:
  - 0xFFFF×0xFFFF must give out_p=0x0001.
  - 0x0100×0x0100 must give 0x0000.
  - 0x00FF×0x0101 must give 0xFFFF.
- Zero and backpressure: in_a=0x1234, in_b=0, with out_ready held low for 10 cycles after out_valid rises. Required: out_p=0x0000 stable, out_valid held high, state stays in DONE until out_ready=1.
- ALU drive check: in_b=0x0001. Required sequence:
  - iteration 0: ADD drives alu_fs=10100, alu_b=in_a.
  - iterations 1–15: ADD drives 01100.
  - every SHL drives 11000; every SHR drives 11010.
  - IDLE drives 00000 with alu_a=alu_b=0.
- Busy-input rejection: present in_valid with new operands on every cycle during busy. Required: in_ready=0 throughout, the result of the first operation is unaffected, and no second accept occurs until IDLE.
- Reset mid-operation: assert rst at iteration 7. Required on the next edge: in_ready=1, busy=0, out_valid=0, out_p=0. A following 7×9 must then yield 0x003F with normal 48-cycle latency.
